// File: rtl/borus_pkg.sv
// Shared definitions for the Borus program-load/run controller.
// Holds the controller state encoding, memory geometry defaults and reset polarity.
package borus_pkg;

    localparam int DEPTH_DEF  = 256;
    localparam int ADDR_W_DEF = $clog2(DEPTH_DEF);

    // Level that holds the core in reset.
    localparam logic CPU_RST_ON = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RELEASE,
        S_RUN,
        S_HALTED
    } state_e;

    function automatic logic state_busy(input state_e s);
        return (s == S_LOAD) || (s == S_RELEASE) || (s == S_RUN);
    endfunction

endpackage

// File: rtl/borus_sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones.
// Clear has priority over enable.
module borus_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/borus_prog_ctrl.sv
// Program-load and run controller for the Borus core: streams host bytes into
// program memory, sequences the core reset, and measures cycles until halt.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | core held in reset, waiting for load_start or run_start
// LOAD    | accepting host bytes into program memory
// RELEASE | core still in reset for RST_HOLD cycles before running
// RUN     | core running, run_cycles counting until cpu_halted
// HALTED  | core halted, run_cycles frozen
module borus_prog_ctrl
    import borus_pkg::*;
#(
    parameter int DEPTH    = DEPTH_DEF,
    parameter int RST_HOLD = 2,
    parameter int CYC_W    = 16,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              run_start,
    input  logic              host_valid,
    input  logic [7:0]        host_data,
    input  logic              host_last,
    output logic              host_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_rst,
    input  logic              cpu_halted,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   prog_len,
    output logic [CYC_W-1:0]  run_cycles
);

    localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RST_HOLD - 1);
    localparam logic [ADDR_W-1:0] PTR_MAX   = ADDR_W'(DEPTH - 1);

    state_e            state, state_nx;
    logic [ADDR_W-1:0] ptr;
    logic [HOLD_W-1:0] hold;
    logic              beat;
    logic              load_entry;
    logic              release_entry;
    logic              last_beat;
    logic              ovf_beat;
    logic              cnt_en;

    assign host_ready = (state == S_LOAD);
    assign beat       = host_valid & host_ready;
    assign mem_we     = beat;
    assign mem_addr   = ptr;
    assign mem_wdata  = host_data;
    assign busy       = state_busy(state);
    assign done       = (state == S_HALTED);

    assign last_beat = beat & host_last;
    assign ovf_beat  = beat & ~host_last & (ptr == PTR_MAX);

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (load_start) begin
                    state_nx = S_LOAD;
                end else if (run_start && (prog_len != '0)) begin
                    state_nx = S_RELEASE;
                end
            end
            S_LOAD: begin
                if (last_beat) begin
                    state_nx = S_RELEASE;
                end else if (ovf_beat) begin
                    state_nx = S_IDLE;
                end
            end
            S_RELEASE: begin
                if (hold == '0) begin
                    state_nx = S_RUN;
                end
            end
            S_RUN: begin
                if (load_start) begin
                    state_nx = S_LOAD;
                end else if (cpu_halted) begin
                    state_nx = S_HALTED;
                end
            end
            S_HALTED: begin
                if (load_start) begin
                    state_nx = S_LOAD;
                end else if (run_start) begin
                    state_nx = S_RELEASE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign load_entry    = (state_nx == S_LOAD) && (state != S_LOAD);
    assign release_entry = (state_nx == S_RELEASE) && (state != S_RELEASE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Registered so the core sees a glitch-free reset that tracks the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_rst <= CPU_RST_ON;
        end else if ((state_nx == S_RUN) || (state_nx == S_HALTED)) begin
            cpu_rst <= ~CPU_RST_ON;
        end else begin
            cpu_rst <= CPU_RST_ON;
        end
    end

    // The pointer never wraps: the beat at PTR_MAX either ends or overflows the load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (load_entry) begin
            ptr <= '0;
        end else if (beat && !host_last && (ptr != PTR_MAX)) begin
            ptr <= ptr + 1'b1;
        end
    end

    // A new load invalidates whatever program was resident before.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err      <= 1'b0;
            prog_len <= '0;
        end else if (load_entry) begin
            err      <= 1'b0;
            prog_len <= '0;
        end else if (last_beat) begin
            prog_len <= {1'b0, ptr} + 1'b1;
        end else if (ovf_beat) begin
            err      <= 1'b1;
            prog_len <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold <= '0;
        end else if (release_entry) begin
            hold <= HOLD_INIT;
        end else if ((state == S_RELEASE) && (hold != '0)) begin
            hold <= hold - 1'b1;
        end
    end

    assign cnt_en = (state == S_RUN) && !cpu_halted;

    borus_sat_counter #(
        .W (CYC_W)
    ) u_run_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (release_entry),
        .en    (cnt_en),
        .count (run_cycles)
    );

endmodule

// File: tb/tb_borus_prog_ctrl.sv
// Directed bench for borus_prog_ctrl: load, backpressure, overflow, abort,
// re-run with a 4-bit saturating cycle counter, async reset and pulse priority.
module tb_borus_prog_ctrl;

    localparam int DEPTH    = 256;
    localparam int RST_HOLD = 2;
    localparam int CYC_W    = 4;
    localparam int ADDR_W   = 8;

    logic              clk;
    logic              rst_n;
    logic              load_start;
    logic              run_start;
    logic              host_valid;
    logic [7:0]        host_data;
    logic              host_last;
    logic              host_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              cpu_rst;
    logic              cpu_halted;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   prog_len;
    logic [CYC_W-1:0]  run_cycles;

    int n_chk;
    int n_bad;
    int wr_cnt;
    logic [7:0] mem_model [0:DEPTH-1];
    logic [7:0] wr_addr   [0:7];
    logic [7:0] vec3      [0:2];
    logic [7:0] vec4      [0:3];
    logic [CYC_W-1:0] first_sat;

    borus_prog_ctrl #(
        .DEPTH    (DEPTH),
        .RST_HOLD (RST_HOLD),
        .CYC_W    (CYC_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .run_start  (run_start),
        .host_valid (host_valid),
        .host_data  (host_data),
        .host_last  (host_last),
        .host_ready (host_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_rst    (cpu_rst),
        .cpu_halted (cpu_halted),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .prog_len   (prog_len),
        .run_cycles (run_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program memory model plus a log of the first few write addresses.
    always @(posedge clk) begin
        if (mem_we) begin
            mem_model[mem_addr] = mem_wdata;
            if (wr_cnt < 8) wr_addr[wr_cnt] = mem_addr;
            wr_cnt = wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_run();
        int k;
        k = 0;
        while (cpu_rst && (k < 20)) begin
            @(negedge clk);
            k = k + 1;
        end
        chk("rst_fall", {31'd0, cpu_rst}, 32'd0);
    endtask

    // Core model: runs n unhalted cycles after reset release, then halts.
    task automatic run_core(input int n);
        cpu_halted = 1'b0;
        repeat (n) @(negedge clk);
        cpu_halted = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        n_chk = 0; n_bad = 0; wr_cnt = 0;
        vec3[0] = 8'h05; vec3[1] = 8'h60; vec3[2] = 8'hF0;
        vec4[0] = 8'hA1; vec4[1] = 8'hB2; vec4[2] = 8'hC3; vec4[3] = 8'hD4;
        load_start = 1'b0; run_start = 1'b0;
        host_valid = 1'b1; host_data = 8'h00; host_last = 1'b0;
        cpu_halted = 1'b0;
        rst_n = 1'b0;

        // Reset values, with host_valid high to show mem_we stays low
        @(negedge clk);
        chk("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        chk("rst_ready", {31'd0, host_ready}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_len", 32'(prog_len), 32'd0);
        chk("rst_cycles", 32'(run_cycles), 32'd0);
        host_valid = 1'b0;
        rst_n = 1'b1;

        // run_start with nothing loaded is ignored
        @(negedge clk); run_start = 1'b1;
        @(negedge clk); run_start = 1'b0;
        chk("norun_busy", {31'd0, busy}, 32'd0);
        chk("norun_rst", {31'd0, cpu_rst}, 32'd1);

        // Load and run: 3 bytes
        wr_cnt = 0;
        load_start = 1'b1;
        @(negedge clk); load_start = 1'b0;
        chk("load_ready", {31'd0, host_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            host_valid = 1'b1; host_data = vec3[i]; host_last = (i == 2);
            @(negedge clk);
        end
        host_valid = 1'b0; host_last = 1'b0;
        chk("ld_ready_drop", {31'd0, host_ready}, 32'd0);
        chk("ld_len", 32'(prog_len), 32'd3);
        chk("ld_rst_m1", {31'd0, cpu_rst}, 32'd1);
        @(negedge clk);
        chk("ld_rst_m2", {31'd0, cpu_rst}, 32'd1);
        @(negedge clk);
        chk("ld_rst_m3", {31'd0, cpu_rst}, 32'd0);
        chk("ld_wr_cnt", 32'(wr_cnt), 32'd3);
        for (int i = 0; i < 3; i++) chk("ld_mem", 32'(mem_model[i]), 32'(vec3[i]));
        run_core(3);
        chk("ld_done", {31'd0, done}, 32'd1);
        chk("ld_cycles", 32'(run_cycles), 32'd3);

        // Backpressure gaps: valid 1,0,1,0,... over 4 bytes
        wr_cnt = 0;
        load_start = 1'b1; cpu_halted = 1'b0;
        @(negedge clk); load_start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            host_valid = ((i % 2) == 0);
            host_data  = ((i % 2) == 0) ? vec4[i/2] : 8'hEE;
            host_last  = (i == 6);
            @(negedge clk);
        end
        host_valid = 1'b0; host_last = 1'b0;
        chk("bp_wr_cnt", 32'(wr_cnt), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("bp_addr", 32'(wr_addr[i]), 32'(i));
            chk("bp_mem", 32'(mem_model[i]), 32'(vec4[i]));
        end
        chk("bp_len", 32'(prog_len), 32'd4);
        wait_run();
        run_core(2);
        chk("bp_cycles", 32'(run_cycles), 32'd2);

        // Re-run with a never-halting program: counter saturates at 15
        run_start = 1'b1; cpu_halted = 1'b0;
        @(negedge clk); run_start = 1'b0;
        chk("rr_clear", 32'(run_cycles), 32'd0);
        chk("rr_busy", {31'd0, busy}, 32'd1);
        wait_run();
        run_core(20);
        chk("sat_done", {31'd0, done}, 32'd1);
        chk("sat_cycles", 32'(run_cycles), 32'd15);
        first_sat = run_cycles;
        run_start = 1'b1; cpu_halted = 1'b0;
        @(negedge clk); run_start = 1'b0;
        chk("rr2_clear", 32'(run_cycles), 32'd0);
        wait_run();
        run_core(20);
        chk("rr2_same", 32'(run_cycles), 32'(first_sat));

        // Abort in RUN after 10 cycles
        run_start = 1'b1; cpu_halted = 1'b0;
        @(negedge clk); run_start = 1'b0;
        wait_run();
        repeat (10) @(negedge clk);
        chk("ab_running", {31'd0, busy & ~cpu_rst}, 32'd1);
        load_start = 1'b1;
        @(negedge clk); load_start = 1'b0;
        chk("ab_rst", {31'd0, cpu_rst}, 32'd1);
        chk("ab_load", {31'd0, host_ready}, 32'd1);
        chk("ab_ptr", 32'(mem_addr), 32'd0);
        chk("ab_done", {31'd0, done}, 32'd0);

        // Async reset mid-LOAD
        host_valid = 1'b1; host_data = 8'h11;
        @(negedge clk); host_data = 8'h22;
        @(negedge clk);
        chk("ar_ptr_pre", 32'(mem_addr), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_ready", {31'd0, host_ready}, 32'd0);
        chk("ar_mem_we", {31'd0, mem_we}, 32'd0);
        chk("ar_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        chk("ar_busy", {31'd0, busy}, 32'd0);
        chk("ar_len", 32'(prog_len), 32'd0);
        chk("ar_ptr", 32'(mem_addr), 32'd0);
        chk("ar_cycles", 32'(run_cycles), 32'd0);
        host_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;

        // Overflow: 256 bytes without last
        wr_cnt = 0;
        load_start = 1'b1;
        @(negedge clk); load_start = 1'b0;
        for (int i = 0; i < 256; i++) begin
            host_valid = 1'b1; host_data = 8'(i); host_last = 1'b0;
            @(negedge clk);
        end
        chk("ov_mem_we", {31'd0, mem_we}, 32'd0);
        chk("ov_err", {31'd0, err}, 32'd1);
        chk("ov_len", 32'(prog_len), 32'd0);
        chk("ov_busy", {31'd0, busy}, 32'd0);
        chk("ov_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        chk("ov_mem255", 32'(mem_model[255]), 32'hFF);
        @(negedge clk); host_valid = 1'b0;
        chk("ov_wr_cnt", 32'(wr_cnt), 32'd256);
        run_start = 1'b1;
        @(negedge clk); run_start = 1'b0;
        chk("ov_norun", {31'd0, busy}, 32'd0);
        chk("ov_rst_held", {31'd0, cpu_rst}, 32'd1);
        load_start = 1'b1;
        @(negedge clk); load_start = 1'b0;
        chk("ov_err_clr", {31'd0, err}, 32'd0);

        // One-byte program, then simultaneous pulses in HALTED
        host_valid = 1'b1; host_data = 8'h77; host_last = 1'b1;
        @(negedge clk);
        host_valid = 1'b0; host_last = 1'b0;
        chk("one_len", 32'(prog_len), 32'd1);
        wait_run();
        run_core(1);
        chk("one_cycles", 32'(run_cycles), 32'd1);
        load_start = 1'b1; run_start = 1'b1; cpu_halted = 1'b0;
        @(negedge clk); load_start = 1'b0; run_start = 1'b0;
        chk("both_load", {31'd0, host_ready}, 32'd1);
        chk("both_rst", {31'd0, cpu_rst}, 32'd1);
        chk("both_done", {31'd0, done}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/borus_prog_ctrl.md
# borus_prog_ctrl

Program-load and run controller for the Borus CPU core. It owns the core's reset line and the write port of the writable 256×8 program memory. It streams a program from a host byte interface into that memory, then releases the core from reset. It measures cycles until the core reports halt, and supports re-run and abort/reload.

## Interface
Parameters:
- DEPTH, 256, program memory depth in bytes; address width ADDR_W = clog2(DEPTH) = 8
- RST_HOLD, 2, cycles `cpu_rst` is held in RELEASE before the core runs (≥1)
- CYC_W, 16, width of the run-cycle counter

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- load_start  in  1  single-cycle pulse: begin loading a new program
- run_start  in  1  single-cycle pulse: re-run the loaded program
- host_valid  in  1  host byte valid
- host_data  in  8  host program byte
- host_last  in  1  marks the final byte of the program
- host_ready  out  1  controller accepts a byte
- mem_we  out  1  program-memory write enable
- mem_addr  out  ADDR_W  program-memory write address
- mem_wdata  out  8  program-memory write data
- cpu_rst  out  1  active-high reset to the core; registered
- cpu_halted  in  1  core halted flag
- busy  out  1  high in LOAD, RELEASE, RUN
- done  out  1  high in HALTED
- err  out  1  sticky overflow flag; cleared by the next `load_start`
- prog_len  out  ADDR_W+1  bytes in the last successful load (0 = none)
- run_cycles  out  CYC_W  cycles spent in RUN, saturating

## Operation
States and transitions:
- IDLE
  - `load_start` → LOAD.
  - `run_start` with `prog_len`≠0 → RELEASE.
  - `run_start` with `prog_len`=0 is ignored.
- LOAD
  - On entry: write pointer = 0, `err` = 0.
  - `host_ready` = 1.
  - Each beat (`host_valid & host_ready`) writes one byte; the pointer then increments.
  - Accepted beat with `host_last` → RELEASE; `prog_len` = pointer+1.
  - Accepted beat at pointer DEPTH-1 without `host_last` → IDLE with `err` = 1 and `prog_len` = 0. The pointer never wraps.
  - `load_start` and `run_start` are ignored.
- RELEASE
  - `cpu_rst` = 1 for exactly RST_HOLD cycles, then → RUN.
  - `run_cycles` is cleared on entry.
- RUN
  - `cpu_rst` = 0.
  - `run_cycles` increments every cycle that `cpu_halted` = 0 and stops at all-ones.
  - `cpu_halted` = 1 → HALTED.
  - `load_start` → LOAD (abort); `cpu_rst` reasserts on the next edge.
- HALTED
  - `cpu_rst` = 0; `run_cycles` is frozen.
  - `run_start` → RELEASE; `load_start` → LOAD.

General rules:
- If `load_start` and `run_start` arrive in the same cycle, `load_start` wins.
- `cpu_rst` = 1 in IDLE, LOAD and RELEASE; 0 otherwise.
- Memory port is combinational from registered state:
  - `mem_we` = `host_valid & host_ready`
  - `mem_addr` = write pointer
  - `mem_wdata` = `host_data`
- Reset values: state IDLE, `cpu_rst` 1, `host_ready` 0, `mem_we` 0, `busy` 0, `done` 0, `err` 0, `prog_len` 0, `run_cycles` 0, pointer 0.
- Reset mid-operation: all of the above apply immediately (asynchronously). A partially loaded program leaves `prog_len` = 0.

## Timing
- `load_start` at edge N → LOAD at N+1; `host_ready` is high from cycle N+1.
- One byte per cycle at full throughput; no bubbles between beats.
- Last beat accepted at edge M:
  - RELEASE from M+1.
  - `cpu_rst` falls at M+1+RST_HOLD.
  - The core fetches address 0 on the first edge after that.
- `cpu_halted` sampled high at edge H → HALTED and `done` from H+1.
- `run_cycles` equals the number of RUN cycles with `cpu_halted` low.
- `host_ready` drops on the edge that accepts the last or overflow byte. A beat presented in the following cycle is not accepted.

## Structure
- Shared package `borus_pkg` holds:
  - the state enum (IDLE, LOAD, RELEASE, RUN, HALTED)
  - the DEPTH and ADDR_W defaults
  - the `cpu_rst` polarity constant
- Sub-module `borus_sat_counter` (CYC_W-bit counter with clear, enable and saturation) is used for `run_cycles`.
- The RST_HOLD down-counter stays inline.

## Test plan
- **Load and run:** stream 3 bytes 0x05, 0x60, 0xF0 with last on the third.
  - Memory holds them at addresses 0–2; `prog_len` = 3.
  - `cpu_rst` falls 2 cycles after the last beat.
  - `done` rises; `run_cycles` = 3.
- **Backpressure gaps:** `host_valid` toggles 1,0,1,0 over 4 bytes.
  - Exactly 4 writes at addresses 0–3; no duplicate writes.
- **Overflow:** stream 256 bytes with no last.
  - `err` = 1, `prog_len` = 0, state IDLE, `cpu_rst` held 1.
  - A following `run_start` is ignored.
- **Abort in RUN:** program is a JMP-to-self loop; `load_start` after 10 RUN cycles.
  - `cpu_rst` = 1 on the next edge, state LOAD, pointer 0.
- **Re-run and saturation:** with CYC_W = 4, a program that never halts leaves `run_cycles` pinned at 15.
  - After a halt, `run_start` clears the counter and produces an identical `run_cycles` result.
- **Async reset and simultaneous pulses:**
  - `rst_n` low mid-LOAD → all outputs at reset values before the next edge.
  - `load_start` together with `run_start` in HALTED → LOAD.
